cordic_iter_ctrl: RTL and testbench
===================================

Name: cordic_iter_ctrl

Overview:
Iteration sequencer for the CORDIC engine. It accepts a job (coordinate system plus iteration count) and drives the arctan/arctanh angle-LUT offset and system select for each micro-rotation. It applies the hyperbolic repeat schedule and meters steps into the shift/add datapath with a valid/ready handshake. It sits between the command front-end and the angle LUT/micro-rotation stage.

Parameters:
p_ANGLE_ADDR_WIDTH, 5, width of LUT offset and iteration counters (LUT depth 2**p_ANGLE_ADDR_WIDTH)
p_HYP_REPEAT_A, 4, first hyperbolic offset executed twice
p_HYP_REPEAT_B, 13, second hyperbolic offset executed twice

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  job request
start_ready  out  1  controller can accept a job (high only in IDLE)
start_system  in  1  1 = circular (arctan LUT), 0 = hyperbolic (arctanh LUT)
start_iters  in  p_ANGLE_ADDR_WIDTH  number of micro-rotation steps, repeats included; 0 = no steps
abort  in  1  cancel current job
lut_system  out  1  LUT system select, registered copy of start_system
lut_offset  out  p_ANGLE_ADDR_WIDTH  LUT address and shift amount for the current step
step_valid  out  1  current step presented to datapath
step_ready  in  1  datapath consumes step
step_first  out  1  current step is the first of the job (datapath loads operands)
step_last  out  1  current step is the final one
step_count  out  p_ANGLE_ADDR_WIDTH  steps completed so far in this job
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, job completed normally

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE; lut_offset=0, lut_system=0, step_count=0, step_valid=0, step_first=0, step_last=0, done=0, busy=0; start_ready=1.
- States: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start_valid at edge T, latch system and iters. If iters!=0, go to RUN. If iters==0, go to DONE with no step issued.
- Initial offset on entry to RUN: circular=0; hyperbolic=1, since offset 0 is unused for arctanh. step_count=0 and a repeat_pending flag is cleared.
- RUN: step_valid=1 from T+1. step_first=(step_count==0). step_last=(step_count==iters-1). Outputs hold stable while step_ready=0.
- Step fire = step_valid & step_ready. On fire, step_count increments. Offset advances as follows:
  - Circular: offset+1.
  - Hyperbolic: if offset equals p_HYP_REPEAT_A or p_HYP_REPEAT_B and repeat_pending=0, hold the offset and set repeat_pending.
  - Hyperbolic otherwise: offset+1 and clear repeat_pending.
- Hyperbolic sequence is therefore 1,2,3,4,4,5,...,13,13,14,...
- Fire with step_last=1 goes to DONE. The next step is never presented.
- Offset saturates at all-ones and never wraps. The job still completes at iters steps, repeating the max offset.
- DONE: done=1 for exactly one cycle, step_valid=0, then IDLE. step_count keeps the final count until the next job is accepted.
- Throughput: with step_ready tied high, one step per cycle. Job of N steps: accept at T, steps at T+1..T+N, done at T+N+1, start_ready at T+N+2.
- abort: takes priority over fire in the same cycle. In RUN or DONE it goes to IDLE next cycle, with step_valid=0 and no done pulse. In IDLE it has no effect, and a simultaneous start is ignored (start_ready is still 1, but the job is dropped).
- lut_system changes only on job acceptance.
- Async reset mid-job clears immediately; no done is produced.

Test Plan:
- Circular, iters=5, step_ready=1 -> lut_offset 0,1,2,3,4 at T+1..T+5; step_first only at T+1; step_last only at T+5; done at T+6; step_count=5.
- Hyperbolic, iters=8, step_ready=1 -> offsets 1,2,3,4,4,5,6,7; lut_system=0 throughout; done one cycle after the 8th step.
- Hyperbolic, iters=16 with step_ready toggling 1,0 -> offsets 1..4,4,5..13,13,14 each held while stalled; exactly 16 fires; step_count=16.
- iters=0 -> no step_valid; done pulses at T+1; start_ready high again at T+2.
- Circular, iters=10, abort asserted together with the 3rd fire -> step_valid low next cycle, no done, start_ready=1, next job restarts at offset 0.
- rst_n pulled low during RUN, and start_valid held high during RUN/DONE -> all outputs reset immediately; no start accepted while busy (start_ready=0).

Source files
------------

// File: rtl/cordic_iter_ctrl.sv
// CORDIC iteration sequencer: steps the angle-LUT offset for each micro-rotation,
// applying the hyperbolic repeat schedule, with a valid/ready handshake to the datapath.
//
// state | meaning
// IDLE  | waiting for a job, start_ready high
// RUN   | presenting steps to the shift/add datapath
// DONE  | one-cycle completion pulse
module cordic_iter_ctrl #(
  parameter int p_ANGLE_ADDR_WIDTH = 5,
  parameter int p_HYP_REPEAT_A     = 4,
  parameter int p_HYP_REPEAT_B     = 13
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic                          start_system,
  input  logic [p_ANGLE_ADDR_WIDTH-1:0] start_iters,
  input  logic                          abort,
  output logic                          lut_system,
  output logic [p_ANGLE_ADDR_WIDTH-1:0] lut_offset,
  output logic                          step_valid,
  input  logic                          step_ready,
  output logic                          step_first,
  output logic                          step_last,
  output logic [p_ANGLE_ADDR_WIDTH-1:0] step_count,
  output logic                          busy,
  output logic                          done
);

  localparam int W = p_ANGLE_ADDR_WIDTH;
  localparam logic [W-1:0] OffsetMax = '1;
  localparam logic [W-1:0] RepeatA   = W'(p_HYP_REPEAT_A);
  localparam logic [W-1:0] RepeatB   = W'(p_HYP_REPEAT_B);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, stateNext;
  logic [W-1:0] iters, offset, count;
  logic         system, repeatPending;
  logic         accept, fire, lastStep, repeatHit;

  assign accept    = (state == IDLE) && start_valid && !abort;
  assign fire      = (state == RUN) && step_ready;
  assign lastStep  = (count == iters - W'(1));
  assign repeatHit = !system && !repeatPending && (offset == RepeatA || offset == RepeatB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) stateNext = (start_iters == '0) ? DONE : RUN;
      RUN: begin
        if (abort)                 stateNext = IDLE;
        else if (fire && lastStep) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      system        <= 1'b0;
      iters         <= '0;
      offset        <= '0;
      count         <= '0;
      repeatPending <= 1'b0;
    end else if (accept) begin
      system        <= start_system;
      iters         <= start_iters;
      // arctanh has no entry at offset 0, so hyperbolic jobs start at 1
      offset        <= start_system ? W'(0) : W'(1);
      count         <= '0;
      repeatPending <= 1'b0;
    end else if (fire && !abort) begin
      count <= count + W'(1);
      if (repeatHit) begin
        repeatPending <= 1'b1;
      end else begin
        repeatPending <= 1'b0;
        if (offset != OffsetMax) offset <= offset + W'(1);
      end
    end
  end

  always_comb begin
    start_ready = (state == IDLE);
    busy        = (state != IDLE);
    step_valid  = (state == RUN);
    step_first  = (state == RUN) && (count == '0);
    step_last   = (state == RUN) && lastStep;
    done        = (state == DONE);
    lut_system  = system;
    lut_offset  = offset;
    step_count  = count;
  end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for cordic_iter_ctrl: circular/hyperbolic schedules, stalls,
// zero-length jobs, abort and mid-job reset.
module tb_cordic_iter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic       start_system = 1'b0;
  logic [4:0] start_iters = '0;
  logic       abort = 1'b0;
  logic       lut_system;
  logic [4:0] lut_offset;
  logic       step_valid;
  logic       step_ready = 1'b0;
  logic       step_first;
  logic       step_last;
  logic [4:0] step_count;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cordic_iter_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_system(start_system), .start_iters(start_iters),
    .abort(abort),
    .lut_system(lut_system), .lut_offset(lut_offset),
    .step_valid(step_valid), .step_ready(step_ready),
    .step_first(step_first), .step_last(step_last),
    .step_count(step_count), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic sys, input int n);
    start_valid  = 1'b1;
    start_system = sys;
    start_iters  = 5'(n);
    tick();
    start_valid  = 1'b0;
  endtask

  int hyp8[8]   = '{1, 2, 3, 4, 4, 5, 6, 7};
  int hyp16[16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};
  int fires;

  initial begin
    #2;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_step_valid", step_valid, 0);
    chk("rst_offset", lut_offset, 0);
    chk("rst_done", done, 0);
    #20 rst_n = 1'b1;
    tick();

    // circular, 5 steps, no stalls
    step_ready = 1'b1;
    launch(1'b1, 5);
    for (int i = 0; i < 5; i++) begin
      chk("circ_valid", step_valid, 1);
      chk("circ_offset", lut_offset, i);
      chk("circ_first", step_first, (i == 0) ? 1 : 0);
      chk("circ_last", step_last, (i == 4) ? 1 : 0);
      chk("circ_done_early", done, 0);
      tick();
    end
    chk("circ_done", done, 1);
    chk("circ_valid_off", step_valid, 0);
    chk("circ_count", step_count, 5);
    chk("circ_ready_in_done", start_ready, 0);
    tick();
    chk("circ_done_pulse", done, 0);
    chk("circ_ready_back", start_ready, 1);

    // hyperbolic, 8 steps
    launch(1'b0, 8);
    for (int i = 0; i < 8; i++) begin
      chk("hyp8_offset", lut_offset, hyp8[i]);
      chk("hyp8_system", lut_system, 0);
      chk("hyp8_valid", step_valid, 1);
      tick();
    end
    chk("hyp8_done", done, 1);
    chk("hyp8_count", step_count, 8);
    tick();

    // hyperbolic, 16 steps with alternating stalls
    launch(1'b0, 16);
    fires = 0;
    for (int i = 0; i < 16; i++) begin
      step_ready = 1'b0;
      chk("hyp16_offset", lut_offset, hyp16[i]);
      tick();
      chk("hyp16_hold_offset", lut_offset, hyp16[i]);
      chk("hyp16_hold_valid", step_valid, 1);
      chk("hyp16_hold_count", step_count, i);
      chk("hyp16_hold_last", step_last, (i == 15) ? 1 : 0);
      step_ready = 1'b1;
      if (step_valid) fires++;
      tick();
    end
    step_ready = 1'b1;
    chk("hyp16_fires", fires, 16);
    chk("hyp16_done", done, 1);
    chk("hyp16_count", step_count, 16);
    tick();

    // zero-length job
    launch(1'b1, 0);
    chk("zero_valid", step_valid, 0);
    chk("zero_done", done, 1);
    chk("zero_ready", start_ready, 0);
    tick();
    chk("zero_done_pulse", done, 0);
    chk("zero_ready_back", start_ready, 1);

    // abort on the 3rd fire
    launch(1'b1, 10);
    tick();
    tick();
    chk("abort_offset", lut_offset, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", step_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", start_ready, 1);
    tick();
    chk("abort_no_late_done", done, 0);
    launch(1'b1, 3);
    chk("restart_offset", lut_offset, 0);
    chk("restart_first", step_first, 1);
    tick();
    tick();
    tick();
    chk("restart_done", done, 1);
    tick();

    // abort in IDLE drops a simultaneous start
    start_valid = 1'b1;
    abort = 1'b1;
    tick();
    start_valid = 1'b0;
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_ready", start_ready, 1);

    // start held high while busy; then reset mid-job
    start_valid  = 1'b1;
    start_system = 1'b1;
    start_iters  = 5'd2;
    tick();
    start_system = 1'b0;
    start_iters  = 5'd10;
    chk("hold_ready_run", start_ready, 0);
    chk("hold_system", lut_system, 1);
    tick();
    chk("hold_system2", lut_system, 1);
    chk("hold_last", step_last, 1);
    tick();
    chk("hold_done", done, 1);
    chk("hold_count", step_count, 2);
    chk("hold_ready_done", start_ready, 0);
    tick();
    chk("hold_idle", start_ready, 1);
    tick();
    chk("hold_rerun_offset", lut_offset, 1);
    chk("hold_rerun_system", lut_system, 0);
    tick();
    chk("hold_rerun_offset2", lut_offset, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", step_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_offset", lut_offset, 0);
    chk("mid_rst_count", step_count, 0);
    chk("mid_rst_ready", start_ready, 1);
    chk("mid_rst_done", done, 0);
    start_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
